sm_minmax_tracker: RTL

Streaming min/max tracker for 8-bit sign-magnitude operands, consuming a frame of samples and reporting the frame's minimum, maximum, sample count and status flags. Sits directly downstream of the operand path that feeds the sign-magnitude comparison stage. It reuses the same A-less-than-B ordering rule, applied per accepted sample, to update two running extremes. Results are registered and presented with a one-cycle done pulse for the result/cache writeback logic.

---
 rtl/sm_minmax_tracker_pkg.sv | 11 +
 rtl/sm_minmax_tracker_lt.sv | 13 +
 rtl/sm_minmax_tracker.sv | 65 ++++++
 3 files changed

// File: rtl/sm_minmax_tracker_pkg.sv
// sm_pkg: shared FSM states, status bit indices and sign-magnitude helpers
package sm_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam int ST_NEG = 0;
  localparam int ST_SAT = 1;
  localparam int ST_EQ = 2;
  localparam int ST_NEGZERO = 3;
  function automatic logic [1:0] sm_flags(input logic sign, input logic mag_zero);
    return {sign & mag_zero, sign & ~mag_zero};
  endfunction
endpackage

// File: rtl/sm_minmax_tracker_lt.sv
// sm_lt: sign-magnitude strict less-than with -0 ordered below +0
module sm_lt #(
  parameter int M = 8
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         lt
);
  always_comb
    lt = (a == b) ? 1'b0 :
         (a[M-1] != b[M-1]) ? a[M-1] :
         a[M-1] ? (a[M-2:0] > b[M-2:0]) : (a[M-2:0] < b[M-2:0]);
endmodule

// File: rtl/sm_minmax_tracker.sv
// sm_minmax_tracker: per-frame min/max/count/status of sign-magnitude samples
module sm_minmax_tracker
  import sm_pkg::*;
#(
  parameter int M = 8,
  parameter int C = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [M-1:0] i_data,
  input  logic         i_last,
  output logic [M-1:0] o_min,
  output logic [M-1:0] o_max,
  output logic [C-1:0] o_count,
  output logic [3:0]   o_status,
  output logic         o_done
);
  state_t state_q, state_d;
  logic take, first, lt_min, lt_max, cnt_sat;
  logic [1:0] flags;
  logic [3:0] keep, status_n;
  logic [M-1:0] min_n, max_n;
  logic [C-1:0] cnt_n;
  sm_lt #(.M(M)) u_lt_min (.a(i_data), .b(o_min), .lt(lt_min));
  sm_lt #(.M(M)) u_lt_max (.a(o_max), .b(i_data), .lt(lt_max));
  always_ff @(posedge i_clk)
    state_q <= i_rst ? IDLE : state_d;
  always_comb
    state_d = (state_q == DONE) ? IDLE :
              (take && i_last) ? DONE :
              take ? ACCUM : state_q;
  always_comb begin
    o_ready = state_q != DONE;
    o_done = state_q == DONE;
  end
  always_comb begin
    take = i_valid && o_ready;
    first = state_q == IDLE;
    flags = sm_flags(i_data[M-1], i_data[M-2:0] == '0);
    min_n = (first || lt_min) ? i_data : o_min;
    max_n = (first || lt_max) ? i_data : o_max;
    cnt_sat = o_count == '1;
    cnt_n = first ? C'(1) : cnt_sat ? o_count : o_count + C'(1);
    keep = first ? 4'b0 : o_status;
    status_n = keep;
    status_n[ST_NEG] = keep[ST_NEG] | flags[0];
    status_n[ST_NEGZERO] = keep[ST_NEGZERO] | flags[1];
    status_n[ST_SAT] = keep[ST_SAT] | (!first && cnt_sat);
    status_n[ST_EQ] = min_n == max_n;
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      o_min <= '0;
      o_max <= '0;
      o_count <= '0;
      o_status <= '0;
    end else if (take) begin
      o_min <= min_n;
      o_max <= max_n;
      o_count <= cnt_n;
      o_status <= status_n;
    end
endmodule
